// File: rtl/wrap_counter_sched_pkg.sv
// Shared definitions for the wrap counter scheduler and its counter datapath.
package wrap_counter_sched_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_LO    = 5;
  localparam int DEF_HI    = 14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // One-hot grant vector for a two-requester index.
  function automatic logic [1:0] onehot2(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/wrap_down_counter.sv
// Wrapping down-counter HI..LO with parallel load and out-of-range recovery.
module wrap_down_counter
  import wrap_counter_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LO    = DEF_LO,
  parameter int HI    = DEF_HI
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] CNT,
  output logic             WRAP
);

  localparam logic [WIDTH-1:0] LO_V = WIDTH'(LO);
  localparam logic [WIDTH-1:0] HI_V = WIDTH'(HI);

  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] cnt_q;

  // Next count: load wins, otherwise step on CE; any value outside LO..HI falls back to LO.
  always_comb begin
    cnt_d = cnt_q;
    WRAP  = 1'b0;
    if (LOAD) begin
      cnt_d = LOAD_VAL;
    end else if (CE) begin
      if (cnt_q == LO_V) begin
        cnt_d = HI_V;
        WRAP  = 1'b1;
      end else if ((cnt_q > LO_V) && (cnt_q <= HI_V)) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        cnt_d = LO_V;
      end
    end
  end

  // Count register, reset to the bottom of the sequence.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) cnt_q <= LO_V;
    else      cnt_q <= cnt_d;
  end

  assign CNT = cnt_q;

endmodule

// File: rtl/wrap_counter_sched.sv
// Round-robin scheduler that grants the shared wrap counter to one of two
// clients, prescales its step enable and releases it after LAPS wraps.
module wrap_counter_sched
  import wrap_counter_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LO    = DEF_LO,
  parameter int HI    = DEF_HI,
  parameter int DIV   = 4,
  parameter int LAPS  = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       REQ,
  input  logic [WIDTH-1:0] SEED0,
  input  logic [WIDTH-1:0] SEED1,
  input  logic             ABORT,
  output logic [1:0]       GNT,
  output logic             BUSY,
  output logic             CE_OUT,
  output logic [WIDTH-1:0] CNT,
  output logic             WRAP,
  output logic [1:0]       DONE
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int LW = $clog2(LAPS + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [LW-1:0] LAPS_V    = LW'(LAPS);

  state_t          state_d, state_q;
  logic [1:0]      gnt_d, gnt_q;
  logic [1:0]      done_d, done_q;
  logic            last_d, last_q;
  logic [PW-1:0]   presc_d, presc_q;
  logic [LW-1:0]   lap_d, lap_q;
  logic            ce;
  logic            load;
  logic            stop;
  logic            cnt_wrap;
  logic [WIDTH-1:0] load_val;

  // A grant ends early on ABORT or when its owner withdraws the request.
  assign stop     = ABORT || ((REQ & gnt_q) == 2'b00);
  assign load_val = gnt_q[1] ? SEED1 : SEED0;

  // Next-state logic: arbitration, load, prescaled stepping and lap counting.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = 2'b00;
    last_d  = last_q;
    presc_d = presc_q;
    lap_d   = lap_q;
    ce      = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (REQ != 2'b00) begin
          // On a tie the requester that was not served last wins.
          gnt_d   = onehot2((REQ == 2'b11) ? ~last_q : REQ[1]);
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (stop) begin
          gnt_d   = 2'b00;
          last_d  = gnt_q[1];
          state_d = ST_IDLE;
        end else begin
          load    = 1'b1;
          presc_d = '0;
          lap_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          // Termination takes priority over any step in this cycle, so CNT holds.
          gnt_d   = 2'b00;
          last_d  = gnt_q[1];
          state_d = ST_IDLE;
        end else if (presc_q == PRESC_MAX) begin
          ce      = 1'b1;
          presc_d = '0;
          if (cnt_wrap) begin
            lap_d = lap_q + LW'(1);
            if ((lap_q + LW'(1)) == LAPS_V) begin
              done_d  = gnt_q;
              gnt_d   = 2'b00;
              last_d  = gnt_q[1];
              state_d = ST_DONE;
            end
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers; LAST starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      last_q  <= 1'b1;
      presc_q <= '0;
      lap_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      last_q  <= last_d;
      presc_q <= presc_d;
      lap_q   <= lap_d;
    end
  end

  wrap_down_counter #(
    .WIDTH (WIDTH),
    .LO    (LO),
    .HI    (HI)
  ) u_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .CE       (ce),
    .LOAD     (load),
    .LOAD_VAL (load_val),
    .CNT      (CNT),
    .WRAP     (cnt_wrap)
  );

  assign GNT    = gnt_q;
  assign DONE   = done_q;
  assign BUSY   = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign CE_OUT = ce;
  assign WRAP   = cnt_wrap;

endmodule
